// File: rtl/decode_pkg.sv
// Shared decode definitions: base opcodes and the immediate-format encoding.
package decode_pkg;

  // RV32I/RV64I base opcodes, instr[6:0]
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_IMM32  = 7'b0011011;
  localparam logic [6:0] OP_R32    = 7'b0111011;

  // Immediate format selector, encoding is visible on the imm_src port
  typedef enum logic [2:0] {
    IMM_I = 3'b000,
    IMM_S = 3'b001,
    IMM_B = 3'b010,
    IMM_U = 3'b011,
    IMM_J = 3'b100
  } imm_src_t;

endpackage

// File: rtl/imm_gen.sv
// Immediate generator: assembles the I/S/B/U/J immediate from an instruction
// word and sign-extends it from instr[31] to XLEN. Purely combinational so the
// execute stage can reuse it.
module imm_gen
  import decode_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  input  imm_src_t        imm_src,
  output logic [XLEN-1:0] imm_ext
);

  // Every format fits in 32 bits once sign-extended to 32; widening is a
  // single signed cast afterwards, which avoids zero-width replications.
  logic [31:0] imm32;

  // Select the bit layout of the requested immediate format
  always_comb begin
    // NOTE: default assignment first so every path drives imm32 and no latch is inferred.
    imm32 = {{20{instr[31]}}, instr[31:20]};
    case (imm_src)
      IMM_I:   imm32 = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm32 = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:   imm32 = {instr[31:12], 12'b0};
      IMM_J:   imm32 = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

  assign imm_ext = XLEN'($signed(imm32));

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage between fetch and register-file/execute: decodes the
// opcode to an immediate format, builds the immediate, extracts register
// fields, and counts illegal opcodes. valid/ready handshake with flush.
module decode_stage
  import decode_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr_i,
  input  logic [XLEN-1:0]  pc_i,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2:0]       imm_src,
  output logic [XLEN-1:0]  imm_ext,
  output logic [4:0]       rs1,
  output logic [4:0]       rs2,
  output logic [4:0]       rd,
  output logic [XLEN-1:0]  pc_o,
  output logic             illegal,
  output logic [CNT_W-1:0] ill_count
);

  imm_src_t        dec_src;
  logic            dec_illegal;
  logic            dec_no_imm;
  logic [XLEN-1:0] gen_imm;
  imm_src_t        imm_src_q;
  logic            load;

  // The stage accepts whenever its register is empty or is draining this cycle
  assign in_ready = !out_valid || out_ready;
  assign load     = in_valid && in_ready && !flush;
  assign imm_src  = imm_src_q;

  // Opcode to immediate-format decode (successor of the ImmSrc decoder)
  always_comb begin
    dec_src     = IMM_I;
    dec_illegal = 1'b0;
    dec_no_imm  = 1'b0;
    case (instr_i[6:0])
      OP_LOAD, OP_IMM, OP_JALR: dec_src = IMM_I;
      OP_STORE:                 dec_src = IMM_S;
      OP_BRANCH:                dec_src = IMM_B;
      OP_LUI, OP_AUIPC:         dec_src = IMM_U;
      OP_JAL:                   dec_src = IMM_J;
      OP_R:                     dec_no_imm = 1'b1;
      OP_IMM32: begin
        // Word-sized ops exist only on the 64-bit datapath
        if (XLEN == 64) begin
          dec_src = IMM_I;
        end else begin
          dec_illegal = 1'b1;
          dec_no_imm  = 1'b1;
        end
      end
      OP_R32: begin
        dec_no_imm = 1'b1;
        if (XLEN != 64) dec_illegal = 1'b1;
      end
      default: begin
        dec_illegal = 1'b1;
        dec_no_imm  = 1'b1;
      end
    endcase
  end

  imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .instr   (instr_i),
    .imm_src (dec_src),
    .imm_ext (gen_imm)
  );

  // Payload register and illegal counter; priority reset > flush > load > drain
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      out_valid <= 1'b0;
      imm_src_q <= IMM_I;
      imm_ext   <= '0;
      rs1       <= '0;
      rs2       <= '0;
      rd        <= '0;
      pc_o      <= '0;
      illegal   <= 1'b0;
      ill_count <= '0;
    end else if (flush) begin
      // Incoming word is consumed and dropped; payload is left as it was
      out_valid <= 1'b0;
    end else if (load) begin
      out_valid <= 1'b1;
      imm_src_q <= dec_src;
      imm_ext   <= dec_no_imm ? '0 : gen_imm;
      rs1       <= instr_i[19:15];
      rs2       <= instr_i[24:20];
      rd        <= instr_i[11:7];
      pc_o      <= pc_i;
      illegal   <= dec_illegal;
      if (dec_illegal && (ill_count != '1)) begin
        ill_count <= ill_count + CNT_W'(1);
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: a 32-bit instance with a 2-bit counter and
// a 64-bit instance with the default counter, driven by the same stimulus.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        flush;
  logic        out_ready;
  logic [31:0] instr;
  logic [63:0] pc64;
  logic [31:0] pc32;

  logic        a_in_ready, a_out_valid, a_illegal;
  logic [2:0]  a_imm_src;
  logic [31:0] a_imm_ext, a_pc_o;
  logic [4:0]  a_rs1, a_rs2, a_rd;
  logic [1:0]  a_ill_count;

  logic        b_in_ready, b_out_valid, b_illegal;
  logic [2:0]  b_imm_src;
  logic [63:0] b_imm_ext, b_pc_o;
  logic [4:0]  b_rs1, b_rs2, b_rd;
  logic [15:0] b_ill_count;

  int errors = 0;
  int checks = 0;

  assign pc32 = pc64[31:0];

  always #5 clk = ~clk;

  decode_stage #(.XLEN(32), .CNT_W(2)) dut32 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(a_in_ready),
    .instr_i(instr), .pc_i(pc32), .flush(flush), .out_valid(a_out_valid),
    .out_ready(out_ready), .imm_src(a_imm_src), .imm_ext(a_imm_ext),
    .rs1(a_rs1), .rs2(a_rs2), .rd(a_rd), .pc_o(a_pc_o),
    .illegal(a_illegal), .ill_count(a_ill_count)
  );

  decode_stage #(.XLEN(64), .CNT_W(16)) dut64 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(b_in_ready),
    .instr_i(instr), .pc_i(pc64), .flush(flush), .out_valid(b_out_valid),
    .out_ready(out_ready), .imm_src(b_imm_src), .imm_ext(b_imm_ext),
    .rs1(b_rs1), .rs2(b_rs2), .rd(b_rd), .pc_o(b_pc_o),
    .illegal(b_illegal), .ill_count(b_ill_count)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    instr = '0; pc64 = '0;
    step();
    step();
    check("rst out_valid", a_out_valid, 0);
    check("rst in_ready", a_in_ready, 1);
    check("rst imm_ext", a_imm_ext, 0);
    check("rst ill_count", a_ill_count, 0);
    reset = 1'b0;
    step();

    // addi x1,x0,-1
    in_valid = 1'b1; instr = 32'hFFF00093; pc64 = 64'h100;
    step();
    in_valid = 1'b0;
    check("addi out_valid", a_out_valid, 1);
    check("addi imm_src", a_imm_src, 3'b000);
    check("addi imm_ext32", a_imm_ext, 64'hFFFF_FFFF);
    check("addi rd", a_rd, 1);
    check("addi rs1", a_rs1, 0);
    check("addi pc_o", a_pc_o, 64'h100);
    check("addi illegal", a_illegal, 0);
    check("addi imm_ext64", b_imm_ext, 64'hFFFF_FFFF_FFFF_FFFF);
    step();
    check("drain out_valid", a_out_valid, 0);

    // Back-to-back stream sw / beq / lui / jal
    in_valid = 1'b1; instr = 32'h00112223; pc64 = 64'h200;
    step();
    check("sw imm_src", a_imm_src, 3'b001);
    check("sw imm_ext", a_imm_ext, 64'h4);
    check("sw rs1", a_rs1, 2);
    check("sw rs2", a_rs2, 1);
    instr = 32'hFE000CE3; pc64 = 64'h204;
    step();
    check("beq out_valid", a_out_valid, 1);
    check("beq imm_src", a_imm_src, 3'b010);
    check("beq imm_ext", a_imm_ext, 64'hFFFF_FFF8);
    check("beq imm_ext64", b_imm_ext, 64'hFFFF_FFFF_FFFF_FFF8);
    instr = 32'h123452B7; pc64 = 64'h208;
    step();
    check("lui out_valid", a_out_valid, 1);
    check("lui imm_src", a_imm_src, 3'b011);
    check("lui imm_ext", a_imm_ext, 64'h1234_5000);
    check("lui rd", a_rd, 5);
    instr = 32'hFFDFF06F; pc64 = 64'h20C;
    step();
    check("jal out_valid", a_out_valid, 1);
    check("jal imm_src", a_imm_src, 3'b100);
    check("jal imm_ext", a_imm_ext, 64'hFFFF_FFFC);
    check("jal pc_o", a_pc_o, 64'h20C);
    in_valid = 1'b0;
    step();
    check("stream drain", a_out_valid, 0);

    // Backpressure: first word loads, second waits for out_ready
    out_ready = 1'b0; in_valid = 1'b1; instr = 32'h00500113; pc64 = 64'h300;
    step();
    check("bp first valid", a_out_valid, 1);
    check("bp first imm", a_imm_ext, 64'h5);
    instr = 32'h00700193; pc64 = 64'h304;
    for (int i = 0; i < 3; i++) begin
      check("bp in_ready", a_in_ready, 0);
      step();
      check("bp hold valid", a_out_valid, 1);
      check("bp hold imm", a_imm_ext, 64'h5);
      check("bp hold rd", a_rd, 2);
    end
    out_ready = 1'b1;
    #1;
    check("bp release in_ready", a_in_ready, 1);
    step();
    check("bp second valid", a_out_valid, 1);
    check("bp second imm", a_imm_ext, 64'h7);
    check("bp second rd", a_rd, 3);
    in_valid = 1'b0;
    step();
    check("bp drain", a_out_valid, 0);

    // Flush with an illegal word arriving alongside
    in_valid = 1'b1; instr = 32'hFFF00093; pc64 = 64'h400;
    step();
    check("fl pre valid", a_out_valid, 1);
    instr = 32'h0000007F; flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    check("fl out_valid", a_out_valid, 0);
    check("fl ill_count", a_ill_count, 0);
    check("fl illegal kept", a_illegal, 0);
    step();
    check("fl idle valid", a_out_valid, 0);

    // Illegal saturation on the 2-bit counter
    in_valid = 1'b1; instr = 32'h0000007F;
    for (int i = 1; i <= 5; i++) begin
      step();
      check("sat illegal", a_illegal, 1);
      check("sat imm_ext", a_imm_ext, 0);
      check("sat ill_count", a_ill_count, (i < 3) ? i : 3);
    end
    check("sat ill_count64", b_ill_count, 5);

    // R-type, addiw (64-bit only), jalr, auipc
    instr = 32'h002081B3;
    step();
    check("r illegal", a_illegal, 0);
    check("r imm_ext", a_imm_ext, 0);
    check("r rd", a_rd, 3);
    instr = 32'hFFF0009B;
    step();
    check("addiw illegal32", a_illegal, 1);
    check("addiw illegal64", b_illegal, 0);
    check("addiw imm64", b_imm_ext, 64'hFFFF_FFFF_FFFF_FFFF);
    check("addiw ill_count64", b_ill_count, 5);
    instr = 32'h00008067;
    step();
    check("jalr imm_src", a_imm_src, 3'b000);
    check("jalr illegal", a_illegal, 0);
    check("jalr rs1", a_rs1, 1);
    instr = 32'hFFFFF097;
    step();
    check("auipc imm_src", a_imm_src, 3'b011);
    check("auipc imm32", a_imm_ext, 64'hFFFF_F000);
    check("auipc imm64", b_imm_ext, 64'hFFFF_FFFF_FFFF_F000);

    // Reset while holding a stalled payload
    instr = 32'hFFF00093; pc64 = 64'h500;
    step();
    out_ready = 1'b0; reset = 1'b1;
    step();
    reset = 1'b0; in_valid = 1'b0;
    check("mid rst out_valid", a_out_valid, 0);
    check("mid rst ill_count", a_ill_count, 0);
    check("mid rst imm_ext", a_imm_ext, 0);
    check("mid rst rd", a_rd, 0);
    check("mid rst pc_o", a_pc_o, 0);
    check("mid rst imm_src", a_imm_src, 0);
    check("mid rst in_ready", a_in_ready, 1);
    check("mid rst ill_count64", b_ill_count, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Registered instruction-decode pipeline stage with valid/ready handshake, flush, and an illegal-opcode counter.
- Parametrised successor of the combinational opcode-to-ImmSrc decoder. It decodes the full RV32I/RV64I base immediate set (I/S/B/U/J, now including auipc and jalr), builds the sign-extended immediate, and extracts register fields.
- Sits between the fetch register and the register-file/execute stage.

Parameters:
- XLEN, 32, datapath width; legal values 32 or 64; immediate sign-extended to XLEN.
- CNT_W, 16, width of the saturating illegal-instruction counter (>=2).

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high
- in_valid  in  1  fetch presents an instruction
- in_ready  out  1  stage can accept this cycle
- instr_i  in  32  instruction word
- pc_i  in  XLEN  PC of instr_i
- flush  in  1  kill held and incoming instruction (branch redirect)
- out_valid  out  1  decoded payload valid
- out_ready  in  1  downstream accepts
- imm_src  out  3  000 I, 001 S, 010 B, 011 U, 100 J
- imm_ext  out  XLEN  sign-extended immediate
- rs1, rs2, rd  out  5 each  register fields instr[19:15], [24:20], [11:7]
- pc_o  out  XLEN  registered pc_i
- illegal  out  1  opcode not in supported set
- ill_count  out  CNT_W  illegal instructions accepted and not flushed

Behaviour:
- Reset (synchronous, active-high) sets out_valid=0 and all payload outputs to 0 (imm_src=000, imm_ext=0, rs*/rd=0, pc_o=0, illegal=0, ill_count=0). in_ready=1 during and after reset.
- in_ready = !out_valid || out_ready. This is combinational and must not depend on in_valid.
- Load: on in_valid && in_ready && !flush, the payload register captures the decoded instr_i and pc_i, and out_valid=1 next cycle. Latency is exactly 1 cycle.
- Drain: on out_valid && out_ready with no load in the same cycle, out_valid=0 next cycle. With a load in the same cycle, the new payload replaces the old one back-to-back. Full throughput is one instruction per cycle.
- Hold: while out_valid && !out_ready, the payload and out_valid are stable.
- Flush has the highest priority after reset. out_valid=0 next cycle, the incoming instruction is consumed (in_ready still follows its rule) and discarded, and ill_count is not incremented. Payload contents are don't-care but are left unchanged.
- Opcode decode on instr_i[6:0]:
  - 0000011 load, 0010011 OP-IMM, 1100111 jalr → I
  - 0100011 store → S
  - 1100011 branch → B
  - 0110111 lui, 0010111 auipc → U
  - 1101111 jal → J
  - 0110011 R-type → imm_src=000, imm_ext=0 (immediate unused)
  - XLEN=64 only: 0011011 OP-IMM-32 → I, 0111011 OP-32 → R
  - any other value → illegal=1, imm_src=000, imm_ext=0
- Immediate construction, all sign-extended from instr[31] to XLEN:
  - I: instr[31:20]
  - S: {instr[31:25], instr[11:7]}
  - B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}
  - U: {instr[31:12], 12'b0}
  - J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}
- ill_count increments by 1 on each load with illegal decode. It saturates at 2^CNT_W-1 and does not wrap.
- Simultaneous events:
  - reset beats flush, and flush beats load.
  - A drain together with a flush still produces out_valid=0.

Decomposition:
- Shared package decode_pkg holds:
  - opcode localparams: OP_LOAD, OP_IMM, OP_STORE, OP_R, OP_LUI, OP_AUIPC, OP_BRANCH, OP_JAL, OP_JALR, OP_IMM32, OP_R32
  - typedef enum logic[2:0] imm_src_t {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J}
- One combinational sub-module, imm_gen (instr, imm_src → imm_ext, parametrised XLEN), reused later by the execute stage.
- The opcode decode stays inline as the successor of the existing ImmSrc decoder.

Test Plan:
- addi x1,x0,-1 (0xFFF00093), XLEN=32, out_ready=1 → one cycle later out_valid=1, imm_src=000, imm_ext=0xFFFFFFFF, rd=1, rs1=0. Repeat with XLEN=64 → imm_ext=0xFFFFFFFFFFFFFFFF.
- Stream sw x1,4(x2) (0x00112223), beq x0,x0,-8 (0xFE000CE3), lui x5,0x12345 (0x123452B7), jal x0,-4 (0xFFDFF06F) back-to-back → imm_src 001/010/011/100 and imm_ext 0x4 / 0xFFFFFFF8 / 0x12345000 / 0xFFFFFFFC on consecutive cycles, with no bubbles.
- Backpressure: hold out_ready=0 for 3 cycles with in_valid=1 → in_ready=0 after the first load, payload stable, no second load. Release out_ready=1 → the second instruction appears the next cycle.
- Flush: assert flush while out_valid=1 and a new in_valid=1 → out_valid=0 next cycle, the incoming word is dropped, ill_count unchanged even if that word is illegal (0x0000007F).
- Illegal saturation with CNT_W=2: feed 5 words of opcode 1111111 → illegal=1 each cycle, ill_count goes 1,2,3,3,3.
- Reset mid-stream: assert reset while out_valid=1 and out_ready=0 → next cycle out_valid=0, ill_count=0, all payload 0, in_ready=1.
